// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the OTTER hazard/forwarding control block: ALU mux select codes,
// pipeline slot tags and the memory-wait FSM states.
package otter_hazard_pkg;

    localparam int TAG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rs1;
        logic [TAG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
        logic [TAG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } stage_tag_t;

    // True when the slot will deliver a value for register src (x0 never counts).
    function automatic logic tag_writes(input stage_tag_t t, input logic [TAG_AW-1:0] src);
        return t.valid && t.reg_write && (t.rd != '0) && (t.rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// One ALU operand forwarding select, derived purely from the MEM and WB slot tags.
module fwd_sel_logic
    import otter_hazard_pkg::*;
(
    input  logic [TAG_AW-1:0] src,
    input  logic              use_src,
    input  stage_tag_t        mem_tag,
    input  stage_tag_t        wb_tag,
    output fwd_sel_e          sel
);

    // The younger producer (MEM) holds the newer value, so it wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (use_src && tag_writes(mem_tag, src)) begin
            sel = FWD_MEM;
        end else if (use_src && tag_writes(wb_tag, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for the 5-stage OTTER pipeline.
// Define HAZ_STALL_CNT_EN to build the saturating stall-cycle counter; otherwise STALL_CNT reads 0.
module hazard_fwd_ctrl
    import otter_hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 32,
    parameter int REG_AW      = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [REG_AW-1:0]      ID_RS1,
    input  logic [REG_AW-1:0]      ID_RS2,
    input  logic                   ID_USE_RS1,
    input  logic                   ID_USE_RS2,
    input  logic [REG_AW-1:0]      ID_RD,
    input  logic                   ID_REG_WRITE,
    input  logic                   ID_MEM_READ,
    input  logic                   EX_BRANCH_TAKEN,
    input  logic                   MEM_BUSY,
    output logic [1:0]             FWD_A_SEL,
    output logic [1:0]             FWD_B_SEL,
    output logic                   STALL_PC,
    output logic                   STALL_IFID,
    output logic                   FLUSH_IFID,
    output logic                   BUBBLE_EX,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    stage_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    stage_tag_t id_tag;
    hz_state_e  state_q, state_d;
    fwd_sel_e   fwd_a, fwd_b;
    logic       load_use;
    logic       stall_pc, stall_ifid, flush_ifid, bubble_ex;

    fwd_sel_logic u_fwd_a (
        .src     (ex_q.rs1),
        .use_src (ex_q.use1),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_a)
    );

    fwd_sel_logic u_fwd_b (
        .src     (ex_q.rs2),
        .use_src (ex_q.use2),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_b)
    );

    always_comb begin
        id_tag.valid     = 1'b1;
        id_tag.rs1       = TAG_AW'(ID_RS1);
        id_tag.rs2       = TAG_AW'(ID_RS2);
        id_tag.use1      = ID_USE_RS1;
        id_tag.use2      = ID_USE_RS2;
        id_tag.rd        = TAG_AW'(ID_RD);
        id_tag.reg_write = ID_REG_WRITE;
        id_tag.mem_read  = ID_MEM_READ;

        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                   ((ID_USE_RS1 && (ex_q.rd == id_tag.rs1)) ||
                    (ID_USE_RS2 && (ex_q.rd == id_tag.rs2)));

        // Priority: memory wait freezes everything, then branch flush, then load-use.
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        bubble_ex  = 1'b0;
        if (!RST) begin
            if (MEM_BUSY) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end else if (EX_BRANCH_TAKEN) begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end else if (load_use) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            RUN:      if (MEM_BUSY)  state_d = MEM_WAIT;
            MEM_WAIT: if (!MEM_BUSY) state_d = RUN;
            default:  state_d = RUN;
        endcase

        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!MEM_BUSY) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = bubble_ex ? '0 : id_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign FWD_A_SEL  = RST ? 2'b00 : fwd_a;
    assign FWD_B_SEL  = RST ? 2'b00 : fwd_b;
    assign STALL_PC   = stall_pc;
    assign STALL_IFID = stall_ifid;
    assign FLUSH_IFID = flush_ifid;
    assign BUBBLE_EX  = bubble_ex;

`ifdef HAZ_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = RST ? '0 : stall_cnt_q;
`else
    assign STALL_CNT = '0;
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline control block for the 5-stage OTTER core; it produces the 2-bit select codes consumed by the EX-stage ALU operand Mux4 instances.
- Tracks destination/source register tags for EX, MEM and WB in internal registered slots, fed from ID-stage decode each advancing cycle.
- From those slots it derives forwarding selects, load-use stalls, taken-branch flushes and memory-wait freezes.
- Also keeps a saturating count of stall cycles.

Parameters:
- STALL_CNT_W, 32, width of the stall-cycle counter.
- REG_AW, 5, register index width.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- ID_RS1  in  REG_AW  rs1 of the instruction in ID.
- ID_RS2  in  REG_AW  rs2 of the instruction in ID.
- ID_USE_RS1  in  1  the ID instruction reads rs1.
- ID_USE_RS2  in  1  the ID instruction reads rs2.
- ID_RD  in  REG_AW  rd of the ID instruction.
- ID_REG_WRITE  in  1  the ID instruction writes rd.
- ID_MEM_READ  in  1  the ID instruction is a load.
- EX_BRANCH_TAKEN  in  1  branch/jump in EX redirects the PC.
- MEM_BUSY  in  1  data memory not ready; the whole pipe must hold.
- FWD_A_SEL  out  2  ALU operand A mux select.
- FWD_B_SEL  out  2  ALU operand B mux select.
- STALL_PC  out  1  hold the PC.
- STALL_IFID  out  1  hold the IF/ID register.
- FLUSH_IFID  out  1  clear IF/ID to a NOP.
- BUBBLE_EX  out  1  load a NOP into ID/EX.
- STALL_CNT  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Slot contents:
  - Slots EX, MEM and WB each hold {valid, rs1, rs2, use1, use2, rd, reg_write, mem_read}.
  - Reset clears all slots to invalid, the FSM to RUN and STALL_CNT to 0.
  - All outputs are 0 during and after reset until hazards arise.
- Select encoding: 00 = regfile value, 01 = MEM ALU result, 10 = WB writeback data, 11 = reserved (never driven).
- Forwarding is combinational from slot state only (zero latency, no dependence on ID inputs). For operand A:
  - 01 when MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.use1.
  - Otherwise 10 under the same test against the WB slot.
  - Otherwise 00.
  - MEM has priority over WB. Operand B is identical using rs2/use2.
  - rd==0 never forwards.
- Load-use hazard:
  - Condition: EX.valid & EX.mem_read & EX.rd!=0 & EX.rd matches ID_RS1 (with ID_USE_RS1) or ID_RS2 (with ID_USE_RS2).
  - Response: STALL_PC=1, STALL_IFID=1, BUBBLE_EX=1.
  - Next edge: EX slot becomes invalid, while MEM and WB advance.
- Branch flush:
  - EX_BRANCH_TAKEN gives FLUSH_IFID=1 and BUBBLE_EX=1, with no stall.
  - Next edge: EX slot becomes invalid.
  - Flush has priority over load-use; STALL_PC and STALL_IFID are forced to 0 when both are present.
- FSM states:
  - RUN: normal operation.
    - On each edge, WB<=MEM, MEM<=EX, and EX<=ID tags, or invalid if bubbled.
    - On MEM_BUSY=1, go to MEM_WAIT.
  - MEM_WAIT: entered on the edge where MEM_BUSY was sampled high.
    - While MEM_BUSY=1, all slots freeze and STALL_PC=STALL_IFID=1.
    - FLUSH_IFID and BUBBLE_EX are 0 here; EX_BRANCH_TAKEN is ignored because EX is frozen, and the branch re-evaluates after release.
    - On MEM_BUSY=0, return to RUN.
  - MEM_BUSY is also honoured combinationally in RUN: in the first busy cycle the stall outputs are asserted and slots do not advance.
- MEM_BUSY has priority over flush and over load-use.
- STALL_CNT:
  - Increments by 1 on every edge where STALL_PC=1.
  - Saturates at all-ones; never wraps.
- Reset mid-stall or mid-MEM_WAIT: state returns to RUN and all slots are invalidated on that edge.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- Defined: STALL_CNT is implemented as described.
- Undefined: the counter register is not built and STALL_CNT is tied to 0.

Decomposition:
- Package otter_hazard_pkg holds:
  - enum fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - struct stage_tag_t (slot fields).
  - enum hz_state_e {RUN, MEM_WAIT}.
- Sub-module fwd_sel_logic: pure combinational, computes one operand select from (src, use, MEM tag, WB tag); instantiated twice, for A and B.

Test Plan:
- RAW chain: `add x5` then `sub` using rs1=x5 → FWD_A_SEL=01 the cycle the sub is in EX. The next dependent instruction (rs2=x5, two behind) → FWD_B_SEL=10.
- Load-use: `lw x7` in EX with ID rs1=x7 → exactly 1 cycle of STALL_PC=STALL_IFID=BUBBLE_EX=1. Then FWD_A_SEL=10 for the consumer; STALL_CNT=1.
- x0 guard: producer with rd=0, consumer with rs1=0 → FWD selects stay 00 and no stall, even when the producer is a load.
- Branch vs load-use: EX_BRANCH_TAKEN=1 simultaneous with a load-use match → FLUSH_IFID=1, BUBBLE_EX=1, STALL_PC=0, STALL_CNT unchanged.
- MEM_BUSY high for 3 cycles during a forwarding case → slots frozen, FWD selects constant, STALL_PC high for 3 cycles, STALL_CNT+=3. Then resumes RUN.
- RST pulsed during MEM_WAIT → next cycle all outputs 0, state RUN. Also: the counter forced near max saturates at all-ones; with HAZ_STALL_CNT_EN undefined it reads 0.
